// File: rtl/div8_pkg.sv
// Shared types and constants for the div8 sequential divider.
// Optional two's-complement mode is enabled by defining DIV8_SIGNED_EN.
package div8_pkg;

  // Default operand, quotient and remainder width
  localparam int DIV8_WIDTH = 8;

  // Quotient reported when the divisor is zero (all ones)
  localparam logic [DIV8_WIDTH-1:0] DBZ_QUOTIENT = '1;

  // Controller states; SIGN_FIX is only visited in the signed build
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    SIGN_FIX = 2'd2,
    FINISH   = 2'd3
  } div8_state_e;

endpackage

// File: rtl/div8_trial_sub.sv
// Trial subtractor for the restoring divider: a - b over WIDTH+1 bits,
// built as a ripple chain of full-adder cells with b inverted and carry-in 1.
// neg_o is high when the subtraction borrows (a < b).
module div8_trial_sub
  import div8_pkg::*;
#(
  parameter int WIDTH = DIV8_WIDTH
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  output logic [WIDTH:0] diff_o,
  output logic           neg_o
);

  logic [WIDTH+1:0] carry;
  logic [WIDTH:0]   bInv;

  assign carry[0] = 1'b1;
  assign bInv     = ~b_i;

  // One full-adder cell per bit, carry rippling from LSB to MSB
  for (genvar i = 0; i <= WIDTH; i++) begin : gFullAdder
    assign diff_o[i]  = a_i[i] ^ bInv[i] ^ carry[i];
    assign carry[i+1] = (a_i[i] & bInv[i]) | (carry[i] & (a_i[i] ^ bInv[i]));
  end

  // No carry out of the top cell means the result went negative
  assign neg_o = ~carry[WIDTH+1];

endmodule

// File: rtl/div8_seq.sv
// Sequential restoring divider, one quotient bit per clock.
// Define DIV8_SIGNED_EN for two's-complement operands; this adds a SIGN_FIX
// cycle that restores the signs after the magnitude division.
module div8_seq
  import div8_pkg::*;
#(
  parameter int WIDTH = DIV8_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] DBZ_Q    = WIDTH'(signed'(DBZ_QUOTIENT));

  div8_state_e state_q, state_d;

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shiftRem;
  logic [WIDTH:0]   trialDiff;
  logic             trialNeg;
  logic             takeTrial;
  logic [WIDTH-1:0] iterRem;
  logic [WIDTH-1:0] iterQuo;
  logic [WIDTH-1:0] loadDividend;
  logic [WIDTH-1:0] loadDivisor;

`ifdef DIV8_SIGNED_EN
  logic negQuo_q, negQuo_d;
  logic negRem_q, negRem_d;

  assign loadDividend = dividend[WIDTH-1] ? -dividend : dividend;
  assign loadDivisor  = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
  assign loadDividend = dividend;
  assign loadDivisor  = divisor;
`endif

  // Partial remainder shifted left with the next dividend bit brought in
  assign shiftRem = {rem_q, quo_q[WIDTH-1]};

  div8_trial_sub #(
    .WIDTH(WIDTH)
  ) uTrial (
    .a_i   (shiftRem),
    .b_i   ({1'b0, den_q}),
    .diff_o(trialDiff),
    .neg_o (trialNeg)
  );

  // Keep the trial difference only when it did not go negative
  assign takeTrial = ~trialNeg & ~trialDiff[WIDTH];
  assign iterRem   = takeTrial ? trialDiff[WIDTH-1:0] : shiftRem[WIDTH-1:0];
  assign iterQuo   = {quo_q[WIDTH-2:0], takeTrial};

  // Next-state, iteration datapath and result capture
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    den_d       = den_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef DIV8_SIGNED_EN
    negQuo_d    = negQuo_q;
    negRem_d    = negRem_q;
`endif

    case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (start) begin
          count_d = '0;
          rem_d   = '0;
          quo_d   = loadDividend;
          den_d   = loadDivisor;
          dbz_d   = 1'b0;
`ifdef DIV8_SIGNED_EN
          negQuo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          negRem_d = dividend[WIDTH-1];
`endif
          if (divisor == '0) begin
            state_d     = FINISH;
            quotient_d  = DBZ_Q;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        rem_d   = iterRem;
        quo_d   = iterQuo;
        count_d = count_q + CNT_ONE;
        if (count_q == CNT_LAST) begin
          count_d = '0;
`ifdef DIV8_SIGNED_EN
          state_d = SIGN_FIX;
`else
          state_d     = FINISH;
          quotient_d  = iterQuo;
          remainder_d = iterRem;
`endif
        end
      end

`ifdef DIV8_SIGNED_EN
      SIGN_FIX: begin
        state_d     = FINISH;
        quotient_d  = negQuo_q ? -quo_q : quo_q;
        remainder_d = negRem_q ? -rem_q : rem_q;
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      den_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef DIV8_SIGNED_EN
      negQuo_q    <= 1'b0;
      negRem_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      den_q       <= den_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef DIV8_SIGNED_EN
      negQuo_q    <= negQuo_d;
      negRem_q    <= negRem_d;
`endif
    end
  end

  assign busy        = (state_q == RUN) || (state_q == SIGN_FIX);
  assign done        = (state_q == FINISH);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div8_seq.sv
// Directed self-checking bench for div8_seq (WIDTH = 8).
// Expected values adapt when DIV8_SIGNED_EN is defined.
module tb_div8_seq;

`ifdef DIV8_SIGNED_EN
  localparam int         LAT  = 10;
  localparam logic [7:0] Q200 = 8'hFA;
  localparam logic [7:0] R200 = 8'hFE;
`else
  localparam int         LAT  = 9;
  localparam logic [7:0] Q200 = 8'd22;
  localparam logic [7:0] R200 = 8'd2;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int testsRun;
  int testsFailed;
  int lat;

  div8_seq #(
    .WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  // Present an operand pair with start raised; accepted on the next edge
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
  endtask

  // Wait (bounded) for done, checking busy and held results along the way
  task automatic waitDone(input bit hold, input logic [7:0] holdQ, output int latency);
    tick();
    if (!hold) start = 1'b0;
    latency = 1;
    while (done !== 1'b1 && latency < 40) begin
      checkFlag("busyRun", busy, 1'b1);
      checkOutput("heldQuotient", quotient, holdQ);
      if (latency == 1) checkFlag("dbzClear", div_by_zero, 1'b0);
      if (hold && latency == 3) begin
        dividend = 8'd17;
        divisor  = 8'd3;
      end
      tick();
      latency++;
    end
    start = 1'b0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    start       = 1'b0;
    dividend    = 8'd0;
    divisor     = 8'd0;

    // Reset state
    tick();
    tick();
    checkFlag("rstBusy", busy, 1'b0);
    checkFlag("rstDone", done, 1'b0);
    checkOutput("rstQuotient", quotient, 8'd0);
    checkOutput("rstRemainder", remainder, 8'd0);
    checkFlag("rstDbz", div_by_zero, 1'b0);
    rst = 1'b0;
    tick();

    // 100 / 7
    applyStimulus(8'd100, 8'd7);
    waitDone(1'b0, 8'd0, lat);
    checkOutput("lat100", 8'(lat), 8'(LAT));
    checkOutput("q100", quotient, 8'd14);
    checkOutput("r100", remainder, 8'd2);
    checkFlag("dbz100", div_by_zero, 1'b0);
    checkFlag("busyAtDone", busy, 1'b0);
    tick();
    checkFlag("doneStrobe", done, 1'b0);
    checkOutput("q100Held", quotient, 8'd14);
    tick();

    // 255 / 1 followed back-to-back by 3 / 10
    applyStimulus(8'd255, 8'd1);
    waitDone(1'b0, 8'd14, lat);
    checkOutput("q255", quotient, 8'd255);
    checkOutput("r255", remainder, 8'd0);
    applyStimulus(8'd3, 8'd10);
    waitDone(1'b0, 8'd255, lat);
    checkOutput("latBackToBack", 8'(lat), 8'(LAT));
    checkOutput("q3", quotient, 8'd0);
    checkOutput("r3", remainder, 8'd3);
    tick();
    checkFlag("doneStrobe2", done, 1'b0);

    // 5 / 0
    applyStimulus(8'd5, 8'd0);
    waitDone(1'b0, 8'd0, lat);
    checkOutput("latDbz", 8'(lat), 8'd1);
    checkOutput("qDbz", quotient, 8'hFF);
    checkOutput("rDbz", remainder, 8'd5);
    checkFlag("dbzSet", div_by_zero, 1'b1);
    checkFlag("busyDbz", busy, 1'b0);
    tick();
    checkFlag("dbzHeld", div_by_zero, 1'b1);
    checkFlag("doneDbzStrobe", done, 1'b0);

    // 200 / 9 with start held and operands changed mid-run
    applyStimulus(8'd200, 8'd9);
    waitDone(1'b1, 8'hFF, lat);
    checkOutput("lat200", 8'(lat), 8'(LAT));
    checkOutput("q200", quotient, Q200);
    checkOutput("r200", remainder, R200);
    checkFlag("dbz200", div_by_zero, 1'b0);
    tick();
    tick();

    // Reset in the middle of 100 / 7
    applyStimulus(8'd100, 8'd7);
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkFlag("abortBusy", busy, 1'b0);
    checkFlag("abortDone", done, 1'b0);
    checkOutput("abortQuotient", quotient, 8'd0);
    checkOutput("abortRemainder", remainder, 8'd0);
    checkFlag("abortDbz", div_by_zero, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkFlag("noDoneAfterAbort", done, 1'b0);
    end

    // 50 / 5 after the abort
    applyStimulus(8'd50, 8'd5);
    waitDone(1'b0, 8'd0, lat);
    checkOutput("lat50", 8'(lat), 8'(LAT));
    checkOutput("q50", quotient, 8'd10);
    checkOutput("r50", remainder, 8'd0);
    tick();

`ifdef DIV8_SIGNED_EN
    // -100 / 7
    applyStimulus(8'h9C, 8'h07);
    waitDone(1'b0, 8'd10, lat);
    checkOutput("latSigned", 8'(lat), 8'd10);
    checkOutput("qNeg100", quotient, 8'hF2);
    checkOutput("rNeg100", remainder, 8'hFE);
    tick();

    // -128 / -1 overflow case
    applyStimulus(8'h80, 8'hFF);
    waitDone(1'b0, 8'hF2, lat);
    checkOutput("qOverflow", quotient, 8'h80);
    checkOutput("rOverflow", remainder, 8'h00);
    checkFlag("dbzOverflow", div_by_zero, 1'b0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/div8_seq.md
Name: div8_seq

Overview:
Sequential unsigned restoring divider for the cruise-control datapath. It is the inverse operation of the add/subtract adder chain, and is used to derive ratios such as distance/time and error/gain. It accepts one operand pair per start pulse and iterates one quotient bit per clock. Results are presented with a one-cycle done strobe and held until the next operation.

Parameters:
- WIDTH, 8, operand, quotient and remainder width in bits (must be at least 2).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- dividend  in  WIDTH  numerator; latched when start is accepted.
- divisor  in  WIDTH  denominator; latched when start is accepted.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle strobe when results become valid.
- quotient  out  WIDTH  result; held stable from done until the next accepted start.
- remainder  out  WIDTH  result; held stable likewise.
- div_by_zero  out  1  set with done if the latched divisor was 0; held with the results.

Behaviour:
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state=IDLE, iteration counter=0. Reset takes priority over all other inputs and aborts any operation in progress.
- States:
  - IDLE.
  - RUN.
  - FINISH.
- Accept: start=1 with busy=0 (IDLE or FINISH) latches the operands, clears done and div_by_zero, sets busy=1 on the next edge and goes to RUN. Start while busy=1 is ignored; no queueing.
- Divide by zero: if the latched divisor is 0, RUN is skipped and the block goes straight to FINISH on the next edge. In that case quotient = all ones, remainder = dividend, and div_by_zero=1.
- RUN: exactly WIDTH iterations, one per clock. Each iteration:
  - shift {R,Q} left by 1, with Q shifting in from the dividend MSB first;
  - compute trial = {1'b0,R} - {1'b0,D} at WIDTH+1 bits;
  - if trial MSB=0, then R=trial[WIDTH-1:0] and the new Q LSB = 1; otherwise R is unchanged and the new Q LSB = 0.
- Counter: counts 0..WIDTH-1. On the edge where the counter = WIDTH-1, the block goes to FINISH.
- FINISH: lasts one cycle. During it, done=1 and busy=0, and quotient and remainder are valid. The next state is IDLE, or RUN if start=1 in that same cycle (back-to-back operation). done never stays high for more than one cycle.
- Latency: start sampled at edge 0 gives done high in the cycle after edge WIDTH+1. That is 9 cycles for WIDTH=8, and 1 cycle (edge 1) for divide by zero.
- Result registers update only on the transition into FINISH. The outputs do not expose partial values during RUN.
- Input changes on dividend and divisor after acceptance have no effect.

Optional Feature:
- Macro: DIV8_SIGNED_EN.
- When defined:
  - Operands are two's complement.
  - An extra SIGN_FIX state is inserted between RUN and FINISH, adding one cycle of latency. It restores the signs after magnitude division.
  - The quotient truncates toward zero; the remainder takes the sign of the dividend.
  - Overflow case: dividend = -2^(WIDTH-1) and divisor = -1 gives quotient = -2^(WIDTH-1), remainder = 0, and div_by_zero=0.
  - Divide by zero gives quotient = all ones, remainder = dividend, and div_by_zero=1.
- When undefined: unsigned only, with no SIGN_FIX state and the latency stated above.

Decomposition:
- Package div8_pkg holds:
  - the state enum (IDLE, RUN, SIGN_FIX, FINISH);
  - the default WIDTH constant;
  - the divide-by-zero quotient constant (all ones).
- Sub-module div8_trial_sub: a combinational WIDTH+1-bit subtractor returning the difference and a borrow/negative flag. It is built from the team's ripple full-adder cells with B inverted and carry-in=1, consistent with the existing adder/subtractor datapath.

Test Plan:
- 100/7 with start at cycle 0 -> done at cycle 9, quotient=14, remainder=2, div_by_zero=0; busy high for cycles 1-8.
- 255/1 then 3/10, with the second start asserted in the FINISH cycle of the first -> results 255 r0, then 0 r3; the second done arrives exactly 9 cycles after the first.
- 5/0 -> done at cycle 1, quotient=255, remainder=5, div_by_zero=1; div_by_zero clears on the next accepted start.
- 200/9 with start held high throughout plus changed operands mid-run -> the extra starts are ignored and the result is 22 r2.
- rst asserted at cycle 4 of 100/7 -> next cycle all outputs are 0, state=IDLE and no done pulse; a new 50/5 gives 10 r0.
- DIV8_SIGNED_EN, -100/7 (0x9C/0x07) -> quotient=0xF2 (-14), remainder=0xFE (-2), done at cycle 10; -128/-1 -> quotient=0x80, remainder=0.
